dcache_ctrl: RTL

Direct-mapped, write-through, read-allocate cache controller that sequences two internal `mem` instances (tag array and data array) and a slower backing-memory port. It sits between a single CPU-side requester and main memory, serializing one request at a time. It also owns the valid bits, the hit/miss decision and the refill/write-through handshakes.

---
 rtl/dcache_ctrl_if.sv | 34 +++
 rtl/dcache_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl_if.sv
// CPU-side and backing-memory handshake bundle for dcache_ctrl.
// slave = cache controller, master = requester/backing side.
interface dcache_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ready;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mem_ack, mem_rdata,
        output cpu_ready, cpu_rvalid, cpu_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mem_ack, mem_rdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through read-allocate data cache controller.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int INIT  = 1,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic [WIDTH-1:0] data,
    input  logic [AW-1:0]    rdaddress,
    input  logic             rden,
    input  logic [AW-1:0]    wraddress,
    input  logic             wren,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] ram [DEPTH];

    // INIT=1 keeps the last read word on q while rden is low
    always_ff @(posedge clock) begin
        if (wren)
            ram[wraddress] <= data;
        if (rden)
            q <= ram[rdaddress];
        else if (INIT == 0)
            q <= '0;
    end
endmodule

module dcache_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64
) (
    input  logic        clock,
    input  logic        reset,
    dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);
    localparam int IW    = $clog2(DEPTH);
    localparam int TAG_W = ADDR_WIDTH - IW;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        REFILL,
        WTHRU
    } state_t;

    state_t                state;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DEPTH-1:0]      valid;
    logic                  dwr_q;

    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  mreq_q;
    logic                  mwe_q;
    logic [ADDR_WIDTH-1:0] maddr_q;
    logic [DATA_WIDTH-1:0] mwdata_q;

    logic [IW-1:0]         idx_in;
    logic [IW-1:0]         idx_q;
    logic [TAG_W-1:0]      tag_q;
    logic [TAG_W-1:0]      tag_rd;
    logic [DATA_WIDTH-1:0] data_rd;
    logic [DATA_WIDTH-1:0] data_wr;
    logic                  accept;
    logic                  hit;
    logic                  fill;

    assign idx_in  = bus.cpu_addr[IW-1:0];
    assign idx_q   = addr_q[IW-1:0];
    assign tag_q   = addr_q[ADDR_WIDTH-1:IW];
    assign accept  = bus.cpu_req && (state == IDLE);
    assign hit     = valid[idx_q] && (tag_rd == tag_q);
    assign fill    = (state == REFILL) && bus.mem_ack && !reset;
    assign data_wr = fill ? bus.mem_rdata : wdata_q;

    mem #(
        .WIDTH(TAG_W),
        .DEPTH(DEPTH),
        .INIT (1)
    ) u_tag (
        .clock    (clock),
        .data     (tag_q),
        .rdaddress(idx_in),
        .rden     (accept),
        .wraddress(idx_q),
        .wren     (fill),
        .q        (tag_rd)
    );

    // write-hit updates land one edge after LOOKUP, while in WTHRU
    mem #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(DEPTH),
        .INIT (1)
    ) u_data (
        .clock    (clock),
        .data     (data_wr),
        .rdaddress(idx_in),
        .rden     (accept),
        .wraddress(idx_q),
        .wren     (fill || dwr_q),
        .q        (data_rd)
    );

    assign bus.cpu_ready  = (state == IDLE);
    assign bus.cpu_rvalid = rvalid_q;
    assign bus.cpu_rdata  = rdata_q;
    assign bus.mem_req    = mreq_q;
    assign bus.mem_we     = mwe_q;
    assign bus.mem_addr   = maddr_q;
    assign bus.mem_wdata  = mwdata_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            valid    <= '0;
            dwr_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
`ifdef DCACHE_STATS_EN
            stat_hits   <= '0;
            stat_misses <= '0;
`endif
        end else begin
            rvalid_q <= 1'b0;
            dwr_q    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        we_q    <= bus.cpu_we;
                        addr_q  <= bus.cpu_addr;
                        wdata_q <= bus.cpu_wdata;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
`ifdef DCACHE_STATS_EN
                    if (hit)
                        stat_hits <= stat_hits + 32'd1;
                    else
                        stat_misses <= stat_misses + 32'd1;
`endif
                    if (!we_q && hit) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= data_rd;
                        state    <= IDLE;
                    end else begin
                        mreq_q   <= 1'b1;
                        mwe_q    <= we_q;
                        maddr_q  <= addr_q;
                        mwdata_q <= wdata_q;
                        dwr_q    <= we_q && hit;
                        state    <= we_q ? WTHRU : REFILL;
                    end
                end
                REFILL: begin
                    if (bus.mem_ack) begin
                        valid[idx_q] <= 1'b1;
                        rvalid_q     <= 1'b1;
                        rdata_q      <= bus.mem_rdata;
                        mreq_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                WTHRU: begin
                    if (bus.mem_ack) begin
                        mreq_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
